// File: rtl/ifetch_queue_if.sv
// Fetch packet type plus the ICache/decode bus of ifetch_queue.
// NOP encoding may be overridden by defining NOP before this file.
package ifetch_pkg;
  localparam int XLEN = 32;
`ifndef NOP
`define NOP 32'h0000_0013
`endif
  localparam logic [31:0] NOP_INST = `NOP;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
  } if_id_packet_t;
endpackage

interface ifetch_queue_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int IBUF_DEPTH  = 8
);
  import ifetch_pkg::*;

  logic [XLEN-1:0]                  proc2Icache_addr;
  logic                             proc2Icache_req;
  logic [63:0]                      Icache2proc_data;
  logic                             Icache2proc_data_valid;
  logic [$clog2(FETCH_WIDTH+1)-1:0] id_take;
  if_id_packet_t [FETCH_WIDTH-1:0]  if_packet;
  logic [$clog2(IBUF_DEPTH+1)-1:0]  ibuf_count;

  modport master (
    output proc2Icache_addr, proc2Icache_req, if_packet, ibuf_count,
    input  Icache2proc_data, Icache2proc_data_valid, id_take
  );

  modport slave (
    input  proc2Icache_addr, proc2Icache_req, if_packet, ibuf_count,
    output Icache2proc_data, Icache2proc_data_valid, id_take
  );
endinterface

// File: rtl/ifetch_queue.sv
// Fetch stage: PC walker, ICache line unpacker and circular inst queue feeding decode.
// Optional IFETCH_PERF_CNT_EN adds miss-cycle and flush counters.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int              FETCH_WIDTH = 2,
  parameter int              IBUF_DEPTH  = 8,
  parameter int              NUM_REDIR   = 3,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REDIR-1:0]      redir_req,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
  input  logic                      fetch_stall,
  ifetch_queue_if.master            bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]               perf_miss_cycles,
  output logic [31:0]               perf_flushes
`endif
);
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

  typedef enum logic {FETCH, FULL} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [31:0]     buf_inst [IBUF_DEPTH];
  logic [XLEN-1:0] buf_pc   [IBUF_DEPTH];

  logic            any_redir, req, do_enq;
  logic [XLEN-1:0] redir_target, line_pc;
  logic [CW-1:0]   line_n, free, taken, count_drained, count_after;

  // Free space uses the start-of-cycle count, so a same-cycle dequeue gives no credit.
  always_comb begin
    any_redir    = |redir_req;
    redir_target = redir_pc[XLEN-1:0];
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_req[i]) redir_target = redir_pc[i*XLEN +: XLEN];
    end
    line_pc       = {pc[XLEN-1:3], 3'b000};
    line_n        = pc[2] ? CW'(1) : CW'(2);
    free          = DEPTH_C - count;
    taken         = (int'(bus.id_take) < int'(count)) ? CW'(bus.id_take) : count;
    count_drained = count - taken;
    req           = (state == FETCH) && !fetch_stall;
    do_enq        = req && bus.Icache2proc_data_valid && !any_redir && (free >= line_n);
    count_after   = count_drained + (do_enq ? line_n : CW'(0));
  end

  always_comb begin
    bus.proc2Icache_addr = line_pc;
    bus.proc2Icache_req  = req;
    bus.ibuf_count       = count;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      bus.if_packet[i] = '{valid: 1'b0, inst: NOP_INST, PC: '0, NPC: '0};
      if ((i < int'(count)) && !any_redir) begin
        bus.if_packet[i] = '{valid: 1'b1,
                             inst:  buf_inst[head + PW'(i)],
                             PC:    buf_pc[head + PW'(i)],
                             NPC:   buf_pc[head + PW'(i)] + XLEN'(4)};
      end
    end
  end

  // A redirect flushes the queue and discards any line arriving in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (any_redir) begin
      state <= FETCH;
      pc    <= redir_target;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(taken);
      count <= count_after;
      if (do_enq) begin
        if (pc[2]) begin
          buf_inst[tail] <= bus.Icache2proc_data[63:32];
          buf_pc[tail]   <= pc;
        end else begin
          buf_inst[tail]          <= bus.Icache2proc_data[31:0];
          buf_pc[tail]            <= pc;
          buf_inst[tail + PW'(1)] <= bus.Icache2proc_data[63:32];
          buf_pc[tail + PW'(1)]   <= pc + XLEN'(4);
        end
        tail <= tail + PW'(line_n);
        pc   <= pc + (pc[2] ? XLEN'(4) : XLEN'(8));
      end
      if (state == FETCH) begin
        if (do_enq && ((DEPTH_C - count_after) < CW'(2))) state <= FULL;
      end else if ((DEPTH_C - count_drained) >= CW'(2)) begin
        state <= FETCH;
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Saturating counters; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_miss_cycles <= '0;
      perf_flushes     <= '0;
    end else begin
      if (req && !bus.Icache2proc_data_valid && (perf_miss_cycles != 32'hFFFF_FFFF))
        perf_miss_cycles <= perf_miss_cycles + 32'd1;
      if (any_redir && (perf_flushes != 32'hFFFF_FFFF))
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_ifetch_queue;
  import ifetch_pkg::*;

  localparam int FW    = 2;
  localparam int DEPTH = 8;
  localparam int NR    = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NR-1:0]        redir_req;
  logic [NR*XLEN-1:0]   redir_pc;
  logic                 fetch_stall;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]          perf_miss_cycles, perf_flushes;
`endif

  ifetch_queue_if #(.FETCH_WIDTH(FW), .IBUF_DEPTH(DEPTH)) bus ();

  ifetch_queue #(.FETCH_WIDTH(FW), .IBUF_DEPTH(DEPTH), .NUM_REDIR(NR), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .redir_req(redir_req), .redir_pc(redir_pc),
    .fetch_stall(fetch_stall), .bus(bus)
`ifdef IFETCH_PERF_CNT_EN
    , .perf_miss_cycles(perf_miss_cycles), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] inst; logic [XLEN-1:0] pc; } entry_t;

  entry_t          mq[$];
  logic [XLEN-1:0] mpc;
  bit              mfull;
  int              m_miss, m_flush;
  int              tests_run, tests_failed;

  logic            exp_req;
  logic [XLEN-1:0] exp_addr;
  logic [CW-1:0]   exp_count;
  logic            exp_valid [FW];
  logic [31:0]     exp_inst  [FW];
  logic [XLEN-1:0] exp_pc    [FW];

  bit              s_dv, s_stall;
  logic [NR-1:0]   s_rq;
  logic [NR*XLEN-1:0] s_rpc;
  int              s_take;

  function automatic logic [31:0] inst_at(logic [XLEN-1:0] a);
    return {a[31:16] + 16'h0013, a[15:0] ^ 16'h5A5A};
  endfunction

  function automatic void model_reset();
    mq.delete();
    mpc = 32'h0; mfull = 0; m_miss = 0; m_flush = 0;
  endfunction

  // Drive one cycle of inputs, compute the model's view of outputs, move to the sampling edge.
  task automatic cycle_begin(input bit dv, input bit stall, input logic [NR-1:0] rq, input int take);
    logic [XLEN-1:0] line;
    line = {mpc[XLEN-1:3], 3'b000};
    s_dv = dv; s_stall = stall; s_rq = rq; s_take = take; s_rpc = redir_pc;
    bus.Icache2proc_data_valid = dv;
    bus.Icache2proc_data = dv ? {inst_at(line + 32'd4), inst_at(line)} : {$urandom, $urandom};
    bus.id_take = 2'(take);
    fetch_stall = stall;
    redir_req   = rq;
    exp_req   = !mfull && !stall;
    exp_addr  = line;
    exp_count = CW'(mq.size());
    for (int i = 0; i < FW; i++) begin
      exp_valid[i] = (i < mq.size()) && (rq == '0);
      exp_inst[i]  = NOP_INST;
      exp_pc[i]    = '0;
      if (exp_valid[i]) begin
        exp_inst[i] = mq[i].inst;
        exp_pc[i]   = mq[i].pc;
      end
    end
    @(negedge clock);
  endtask

  // Apply the behavioural rules for the clock edge that ends this cycle.
  task automatic cycle_end();
    int n, free, taken;
    bit enq;
    if (exp_req && !s_dv) m_miss++;
    if (s_rq != '0) begin
      for (int i = NR - 1; i >= 0; i--) if (s_rq[i]) mpc = s_rpc[i*XLEN +: XLEN];
      mq.delete();
      mfull = 0;
      m_flush++;
    end else begin
      n     = mpc[2] ? 1 : 2;
      free  = DEPTH - mq.size();
      taken = (s_take < mq.size()) ? s_take : mq.size();
      enq   = !mfull && !s_stall && s_dv && (free >= n);
      repeat (taken) void'(mq.pop_front());
      if (enq) begin
        mq.push_back('{inst_at(mpc), mpc});
        if (n == 2) mq.push_back('{inst_at(mpc + 32'd4), mpc + 32'd4});
        mpc = mpc + 32'(4 * n);
        if (DEPTH - mq.size() < 2) mfull = 1;
      end else if (mfull && (DEPTH - mq.size() >= 2)) begin
        mfull = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    redir_req = '0; redir_pc = '0; fetch_stall = 1'b0;
    bus.Icache2proc_data_valid = 1'b0; bus.Icache2proc_data = '0; bus.id_take = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset_dut();
    cycle_begin(0, 0, '0, 0);
    tests_run++;
    if (bus.ibuf_count !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_count got %0d want 0", bus.ibuf_count);
    end
    tests_run++;
    if (bus.proc2Icache_req !== 1'b1 || bus.proc2Icache_addr !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_req got req=%b addr=%h want req=1 addr=0", bus.proc2Icache_req, bus.proc2Icache_addr);
    end
    for (int i = 0; i < FW; i++) begin
      tests_run++;
      if (bus.if_packet[i].valid !== 1'b0 || bus.if_packet[i].inst !== NOP_INST) begin
        tests_failed++;
        $display("[TB] FAIL reset_pkt%0d got v=%b inst=%h want v=0 inst=%h", i, bus.if_packet[i].valid, bus.if_packet[i].inst, NOP_INST);
      end
    end
`ifdef IFETCH_PERF_CNT_EN
    tests_run++;
    if (perf_miss_cycles !== 32'd0 || perf_flushes !== 32'd0) begin
      tests_failed++; $display("[TB] FAIL reset_perf got %0d/%0d want 0/0", perf_miss_cycles, perf_flushes);
    end
`endif
    cycle_end();
  endtask

  // Re-reset, then always hit with no consumption until the queue reports full.
  task automatic test_fill();
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      cycle_begin(1, 0, '0, 0);
      tests_run++;
      if (bus.ibuf_count !== exp_count || bus.proc2Icache_req !== exp_req || bus.proc2Icache_addr !== exp_addr) begin
        tests_failed++;
        $display("[TB] FAIL fill_c%0d got cnt=%0d req=%b addr=%h want cnt=%0d req=%b addr=%h", c,
                 bus.ibuf_count, bus.proc2Icache_req, bus.proc2Icache_addr, exp_count, exp_req, exp_addr);
      end
      cycle_end();
    end
    cycle_begin(1, 0, '0, 0);
    tests_run++;
    if (bus.ibuf_count !== 4'd8 || bus.proc2Icache_req !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL fill_full got cnt=%0d req=%b want 8/0", bus.ibuf_count, bus.proc2Icache_req);
    end
    cycle_end();
  endtask

  task automatic test_redirect_odd();
    redir_pc = {32'h0, 32'h0, 32'h104};
    cycle_begin(1, 0, 3'b001, 0);
    tests_run++;
    if (bus.if_packet[0].valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL redir_valid got %b want 0", bus.if_packet[0].valid);
    end
    cycle_end();
    cycle_begin(1, 0, '0, 0);
    tests_run++;
    if (bus.ibuf_count !== '0 || bus.proc2Icache_addr !== 32'h100) begin
      tests_failed++; $display("[TB] FAIL redir_flush got cnt=%0d addr=%h want 0/100", bus.ibuf_count, bus.proc2Icache_addr);
    end
    cycle_end();
    cycle_begin(0, 0, '0, 0);
    tests_run++;
    if (bus.ibuf_count !== 4'd1 || bus.if_packet[0].PC !== 32'h104 || bus.if_packet[0].inst !== inst_at(32'h104)
        || bus.if_packet[1].valid !== 1'b0 || bus.proc2Icache_addr !== 32'h108) begin
      tests_failed++;
      $display("[TB] FAIL redir_odd got cnt=%0d pc=%h inst=%h v1=%b addr=%h want 1/104/%h/0/108", bus.ibuf_count,
               bus.if_packet[0].PC, bus.if_packet[0].inst, bus.if_packet[1].valid, bus.proc2Icache_addr, inst_at(32'h104));
    end
    cycle_end();
  endtask

  task automatic test_priority();
    redir_pc = {32'h300, 32'h200, 32'h180};
    cycle_begin(1, 0, 3'b110, 1);
    cycle_end();
    cycle_begin(0, 0, '0, 0);
    tests_run++;
    if (bus.proc2Icache_addr !== 32'h200) begin
      tests_failed++; $display("[TB] FAIL prio_110 got addr=%h want 200", bus.proc2Icache_addr);
    end
    cycle_end();
    redir_pc = {32'h300, 32'h200, 32'h400};
    cycle_begin(1, 0, 3'b111, 0);
    tests_run++;
    if (bus.if_packet[0].valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL prio_valid got %b want 0", bus.if_packet[0].valid);
    end
    cycle_end();
    cycle_begin(0, 0, '0, 0);
    tests_run++;
    if (bus.proc2Icache_addr !== 32'h400 || bus.ibuf_count !== '0) begin
      tests_failed++; $display("[TB] FAIL prio_111 got addr=%h cnt=%0d want 400/0", bus.proc2Icache_addr, bus.ibuf_count);
    end
    cycle_end();
  endtask

  // Build count=3 from an odd redirect, then stall while decode drains.
  task automatic test_stall();
    redir_pc = {32'h0, 32'h0, 32'h104};
    cycle_begin(0, 0, 3'b001, 0); cycle_end();
    cycle_begin(1, 0, '0, 0);     cycle_end();
    cycle_begin(1, 0, '0, 0);     cycle_end();
    for (int c = 0; c < 3; c++) begin
      cycle_begin(1, 1, '0, 2);
      tests_run++;
      if (bus.ibuf_count !== CW'(c == 0 ? 3 : (c == 1 ? 1 : 0)) || bus.proc2Icache_req !== 1'b0
          || bus.proc2Icache_addr !== 32'h110) begin
        tests_failed++;
        $display("[TB] FAIL stall_c%0d got cnt=%0d req=%b addr=%h", c, bus.ibuf_count, bus.proc2Icache_req, bus.proc2Icache_addr);
      end
      if (c == 0) begin
        tests_run++;
        if (bus.if_packet[0].PC !== 32'h104 || bus.if_packet[1].PC !== 32'h108 || bus.if_packet[1].NPC !== 32'h10C) begin
          tests_failed++;
          $display("[TB] FAIL stall_order got pc0=%h pc1=%h npc1=%h want 104/108/10c", bus.if_packet[0].PC,
                   bus.if_packet[1].PC, bus.if_packet[1].NPC);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_miss();
    for (int c = 0; c < 5; c++) begin
      cycle_begin(0, 0, '0, 0);
      tests_run++;
      if (bus.proc2Icache_addr !== 32'h110 || bus.ibuf_count !== '0) begin
        tests_failed++; $display("[TB] FAIL miss_c%0d got addr=%h cnt=%0d want 110/0", c, bus.proc2Icache_addr, bus.ibuf_count);
      end
      cycle_end();
    end
`ifdef IFETCH_PERF_CNT_EN
    cycle_begin(0, 1, '0, 0);
    tests_run++;
    if (perf_miss_cycles !== 32'(m_miss) || perf_flushes !== 32'(m_flush)) begin
      tests_failed++;
      $display("[TB] FAIL perf_miss got %0d/%0d want %0d/%0d", perf_miss_cycles, perf_flushes, m_miss, m_flush);
    end
    cycle_end();
`endif
  endtask

  // Random hits, stalls, redirects and consumption; wraps the ring many times.
  task automatic test_random();
    logic [NR-1:0] rq;
    for (int c = 0; c < 600; c++) begin
      rq = '0;
      if ($urandom_range(0, 39) == 0) rq = NR'($urandom_range(1, (1 << NR) - 1));
      redir_pc = {$urandom & 32'hFFFC, $urandom & 32'hFFFC, $urandom & 32'hFFFC};
      cycle_begin($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, rq, $urandom_range(0, 2));
      tests_run++;
      if (bus.ibuf_count !== exp_count || bus.proc2Icache_req !== exp_req || bus.proc2Icache_addr !== exp_addr) begin
        tests_failed++;
        $display("[TB] FAIL rand_ctl c%0d got cnt=%0d req=%b addr=%h want cnt=%0d req=%b addr=%h", c,
                 bus.ibuf_count, bus.proc2Icache_req, bus.proc2Icache_addr, exp_count, exp_req, exp_addr);
      end
      for (int i = 0; i < FW; i++) begin
        tests_run++;
        if (bus.if_packet[i].valid !== exp_valid[i] || bus.if_packet[i].inst !== exp_inst[i]
            || (exp_valid[i] && (bus.if_packet[i].PC !== exp_pc[i] || bus.if_packet[i].NPC !== exp_pc[i] + 32'd4))) begin
          tests_failed++;
          $display("[TB] FAIL rand_pkt%0d c%0d got v=%b inst=%h pc=%h want v=%b inst=%h pc=%h", i, c,
                   bus.if_packet[i].valid, bus.if_packet[i].inst, bus.if_packet[i].PC, exp_valid[i], exp_inst[i], exp_pc[i]);
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_reset_mid();
    cycle_begin(1, 0, '0, 0); cycle_end();
    cycle_begin(1, 0, '0, 0); cycle_end();
    redir_pc = {32'h0, 32'h0, 32'h700};
    redir_req = 3'b001;
    bus.Icache2proc_data_valid = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    cycle_begin(0, 0, '0, 0);
    tests_run++;
    if (bus.proc2Icache_addr !== 32'h0 || bus.ibuf_count !== '0 || bus.proc2Icache_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid got addr=%h cnt=%0d req=%b want 0/0/1", bus.proc2Icache_addr, bus.ibuf_count, bus.proc2Icache_req);
    end
    cycle_end();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_fill();
    test_redirect_odd();
    test_priority();
    test_stall();
    test_miss();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
